// File: rtl/polynomial_axil_slave.sv
// AXI4-Lite slave evaluating RESULT = (A*X + B)*X + C with 32-bit wrap arithmetic.
// Define POLYNOMIAL_IRQ_EN to add the irq output (mirrors the done bit).
module polynomial_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
`ifdef POLYNOMIAL_IRQ_EN
    ,
    output logic                              irq
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_1    = 2'd1;
    localparam logic [1:0] S_2    = 2'd2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [31:0] r_a, r_b, r_c, r_x, r_result;
    logic [31:0] r_acc, r_xs, r_bs, r_cs;
    logic [1:0]  r_state;
    logic        r_busy, r_done;
    logic        r_bvalid, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;

    logic        w_wr_hs, w_rd_hs, w_start;
    logic [2:0]  w_wr_idx, w_rd_idx;
    logic [31:0] w_x_new, w_prod, w_sum, w_rd_mux;
    logic        w_unused;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] s);
        f_merge = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) f_merge[i*8 +: 8] = d[i*8 +: 8];
    endfunction

    // Ready is combinational on valid so back-to-back accesses can land while the
    // two-cycle evaluation is still running; gated by reset so it reads 0 there.
    assign w_wr_hs  = s00_axi_aresetn & s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid;
    assign w_rd_hs  = s00_axi_aresetn & s00_axi_arvalid & ~r_rvalid;
    assign w_wr_idx = s00_axi_awaddr[4:2];
    assign w_rd_idx = s00_axi_araddr[4:2];
    assign w_x_new  = f_merge(r_x, s00_axi_wdata, s00_axi_wstrb);
    assign w_start  = w_wr_hs && (w_wr_idx == 3'd3) && !r_busy;
    assign w_prod   = r_acc * r_xs;
    assign w_sum    = w_prod + ((r_state == S_1) ? r_bs : r_cs);

    always_comb begin
        w_rd_mux = '0;
        case (w_rd_idx)
            3'd0: w_rd_mux = r_a;
            3'd1: w_rd_mux = r_b;
            3'd2: w_rd_mux = r_c;
            3'd3: w_rd_mux = r_x;
            3'd4: w_rd_mux = r_result;
            3'd5: w_rd_mux = {30'd0, r_done, r_busy};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_a <= '0; r_b <= '0; r_c <= '0; r_x <= '0; r_result <= '0;
            r_acc <= '0; r_xs <= '0; r_bs <= '0; r_cs <= '0;
            r_state <= S_IDLE; r_busy <= 1'b0; r_done <= 1'b0;
            r_bvalid <= 1'b0; r_bresp <= OKAY;
        end else begin
            if (r_bvalid && s00_axi_bready) r_bvalid <= 1'b0;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                r_bresp  <= OKAY;
                case (w_wr_idx)
                    3'd0: r_a <= f_merge(r_a, s00_axi_wdata, s00_axi_wstrb);
                    3'd1: r_b <= f_merge(r_b, s00_axi_wdata, s00_axi_wstrb);
                    3'd2: r_c <= f_merge(r_c, s00_axi_wdata, s00_axi_wstrb);
                    3'd3: if (r_busy) r_bresp <= SLVERR; else r_x <= w_x_new;
                    3'd4, 3'd5: r_bresp <= SLVERR;
                    default: ;
                endcase
            end
            // Coefficients are snapshotted so later COEF writes leave this run alone.
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_acc <= r_a; r_xs <= w_x_new; r_bs <= r_b; r_cs <= r_c;
                    r_busy <= 1'b1; r_done <= 1'b0; r_state <= S_1;
                end
                S_1: begin
                    r_acc <= w_sum; r_state <= S_2;
                end
                S_2: begin
                    r_result <= w_sum; r_done <= 1'b1; r_busy <= 1'b0; r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rvalid <= 1'b0; r_rresp <= OKAY; r_rdata <= '0;
        end else begin
            if (r_rvalid && s00_axi_rready) r_rvalid <= 1'b0;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rresp  <= OKAY;
                r_rdata  <= w_rd_mux;
            end
        end
    end

    assign s00_axi_awready = w_wr_hs;
    assign s00_axi_wready  = w_wr_hs;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_arready = w_rd_hs;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rresp   = r_rresp;
    assign s00_axi_rdata   = r_rdata;
`ifdef POLYNOMIAL_IRQ_EN
    assign irq = r_done;
`endif
endmodule

// File: tb/tb_polynomial_axil_slave.sv
// Scoreboard bench for polynomial_axil_slave: stimulus pushes expected responses,
// a negedge monitor pops and compares them against B and R channel beats.
module tb_polynomial_axil_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
`ifdef POLYNOMIAL_IRQ_EN
    logic        irq;
`endif

    polynomial_axil_slave dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready)
`ifdef POLYNOMIAL_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int errors = 0;

    // Reference model: register file plus "evaluation in flight" flag.
    logic [31:0] m_reg [4];
    logic [31:0] m_result, m_pend;
    logic        m_busy, m_done;

    logic [1:0]  wq [$];
    string       wn [$];
    logic [33:0] rq [$];
    string       rn [$];

    function automatic logic [31:0] poly(input logic [31:0] a, b, c, x);
        logic [31:0] r;
        r = a * x * x + b * x + c;
        return r;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old, d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_result = '0; m_pend = '0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] er;
        int n;
        er = 2'b00;
        case (a[4:2])
            3'd0, 3'd1, 3'd2: m_reg[a[3:2]] = apply_strb(m_reg[a[3:2]], d, s);
            3'd3: if (m_busy) er = 2'b10;
                  else begin
                      m_reg[3] = apply_strb(m_reg[3], d, s);
                      m_busy = 1'b1; m_done = 1'b0;
                      m_pend = poly(m_reg[0], m_reg[1], m_reg[2], m_reg[3]);
                  end
            3'd4, 3'd5: er = 2'b10;
            default: ;
        endcase
        wq.push_back(er);
        wn.push_back($sformatf("bresp@%02h", a));
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(awready && wready) && n < 50);
        if (!(awready && wready)) begin
            tests++; errors++;
            $display("FAIL wr_timeout@%02h: got no awready expected awready", a);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        logic [31:0] ed;
        int n;
        case (a[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: ed = m_reg[a[3:2]];
            3'd4: ed = m_result;
            3'd5: ed = {30'd0, m_done, m_busy};
            default: ed = '0;
        endcase
        rq.push_back({2'b00, ed});
        rn.push_back($sformatf("rd@%02h", a));
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) begin
            tests++; errors++;
            $display("FAIL rd_timeout@%02h: got no arready expected arready", a);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    // Long enough for any evaluation in flight to have completed.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        if (m_busy) begin m_busy = 1'b0; m_done = 1'b1; m_result = m_pend; end
    endtask

    task automatic eval(input logic [31:0] a, b, c, x);
        wr(5'h00, a, 4'hF); wr(5'h04, b, 4'hF); wr(5'h08, c, 4'hF); wr(5'h0C, x, 4'hF);
        idle(6);
        rd(5'h10);
    endtask

    // Monitor: each one-cycle B/R beat (ready held high) pops one expectation.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bvalid) begin
                if (wq.size() == 0) check("bresp_unexpected", 34'd1, 34'd0);
                else check(wn.pop_front(), {32'd0, bresp}, {32'd0, wq.pop_front()});
            end
            if (rvalid) begin
                if (rq.size() == 0) check("rdata_unexpected", 34'd1, 34'd0);
                else check(rn.pop_front(), {rresp, rdata}, rq.pop_front());
            end
        end
    end

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {23'd0, awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata[0]},
              34'd0);
        check("reset_rdata", {2'b00, rdata}, 34'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Register readback and first evaluation.
        wr(5'h00, 32'h1, 4'hF); wr(5'h04, 32'h2, 4'hF); wr(5'h08, 32'h3, 4'hF); wr(5'h0C, 32'h4, 4'hF);
        rd(5'h00); rd(5'h04); rd(5'h08);
        idle(6);
        rd(5'h0C); rd(5'h10);

        // Basic evaluation, busy visible on the first poll.
        wr(5'h00, 32'd2, 4'hF); wr(5'h04, 32'd3, 4'hF); wr(5'h08, 32'd5, 4'hF); wr(5'h0C, 32'd4, 4'hF);
        rd(5'h14);
        idle(6);
        rd(5'h10); rd(5'h14); rd(5'h14);
`ifdef POLYNOMIAL_IRQ_EN
        check("irq_done", {33'd0, irq}, 34'd1);
`endif

        // Signed wrap cases.
        eval(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd3);
        eval(32'h0001_0000, 32'd0, 32'd0, 32'h0001_0000);

        // X write while busy, COEF write while busy, write to RESULT.
        wr(5'h00, 32'd7, 4'hF); wr(5'h04, 32'd1, 4'hF); wr(5'h08, 32'd9, 4'hF);
        wr(5'h0C, 32'd5, 4'hF);
        wr(5'h0C, 32'd11, 4'hF);
        idle(6);
        rd(5'h10); rd(5'h0C);
        wr(5'h0C, 32'd2, 4'hF);
        wr(5'h00, 32'd100, 4'hF);
        idle(6);
        rd(5'h10);
        wr(5'h10, 32'hDEAD_BEEF, 4'hF); wr(5'h14, 32'h3, 4'hF);
        rd(5'h10); rd(5'h14);

        // Strobes, including an X write with no strobes that still starts a run.
        wr(5'h00, 32'hAABB_CCDD, 4'hF); wr(5'h00, 32'h1122_3344, 4'b0101); rd(5'h00);
        wr(5'h0C, 32'hFFFF_FFFF, 4'h0);
        idle(6);
        rd(5'h10); rd(5'h0C);

        // Unmapped offsets.
        wr(5'h18, 32'h1234_5678, 4'hF); wr(5'h1C, 32'h1, 4'hF);
        rd(5'h18); rd(5'h1C);

        // Reset one edge after the X handshake.
        wr(5'h00, 32'd3, 4'hF); wr(5'h0C, 32'd6, 4'hF);
        @(posedge clk); #1; rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        check("midrun_reset_outputs", {23'd0, awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata[0]},
              34'd0);
        check("midrun_reset_rdata", {2'b00, rdata}, 34'd0);
`ifdef POLYNOMIAL_IRQ_EN
        check("midrun_reset_irq", {33'd0, irq}, 34'd0);
`endif
        @(posedge clk); #1; rst_n = 1'b1;
        rd(5'h14); rd(5'h10);
        eval(32'd2, 32'd3, 32'd5, 32'd4);

        // Randomized evaluations with random strobes on the coefficients.
        for (int i = 0; i < 20; i++) begin
            wr(5'h00, $urandom, 4'($urandom_range(0, 15)));
            wr(5'h04, $urandom, 4'hF);
            wr(5'h08, $urandom, 4'($urandom_range(0, 15)));
            wr(5'h0C, $urandom, 4'hF);
            if ($urandom_range(0, 1) == 1) rd(5'h14);
            if ($urandom_range(0, 1) == 1) wr(5'h0C, $urandom, 4'hF);
            idle(6);
            rd(5'h10); rd(5'h14);
            rd(5'({$urandom_range(0, 7), 2'b00}));
        end

        idle(10);
        check("scoreboard_drained", 34'(wq.size() + rq.size()), 34'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
        $fatal(1, "timeout");
    end
endmodule
